// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace buffer: mode encodings, FSM states and the stored entry layout.
// Defining RVFI_TRACE_TS_EN adds a 32-bit cycle timestamp as the MSBs of every entry.
package ibex_trace_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM  = 2'b00,
    MODE_RING    = 2'b01,
    MODE_TRIGGER = 2'b10,
    MODE_RSVD    = 2'b11
  } trace_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam int unsigned ORDER_W    = 64;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned INSN_W     = 32;
  localparam int unsigned RD_ADDR_W  = 5;
  localparam int unsigned RD_WDATA_W = 32;
  localparam int unsigned TS_W       = 32;

  typedef struct packed {
`ifdef RVFI_TRACE_TS_EN
    logic [TS_W-1:0]       ts;
`endif
    logic [ORDER_W-1:0]    order;
    logic [PC_W-1:0]       pc;
    logic [INSN_W-1:0]     insn;
    logic [RD_ADDR_W-1:0]  rd_addr;
    logic [RD_WDATA_W-1:0] rd_wdata;
    logic                  trap;
  } trace_entry_t;

  localparam int unsigned ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/ibex_trace_ram.sv
// Trace entry storage: DEPTH x WIDTH, one write port per retire channel, one asynchronous read port.
module ibex_trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NRET  = 1,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                       clk_i,
  input  logic [NRET-1:0]            we_i,
  input  logic [NRET-1:0][AW-1:0]    waddr_i,
  input  logic [NRET-1:0][WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]              raddr_i,
  output logic [WIDTH-1:0]           rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; the pointers and level define which slots hold valid data.
  always_ff @(posedge clk_i) begin
    for (int ch = 0; ch < NRET; ch++) begin
      if (we_i[ch]) mem[waddr_i[ch]] <= wdata_i[ch];
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retire trace buffer with STREAM / RING / TRIGGER capture modes and a ready/valid drain port.
// Defining RVFI_TRACE_TS_EN enables the free-running timestamp prepended to each entry.
module ibex_rvfi_trace_buffer
  import ibex_trace_pkg::*;
#(
  parameter int unsigned NRET      = 1,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NRET-1:0]          rvfi_valid,
  input  logic [64*NRET-1:0]       rvfi_order,
  input  logic [32*NRET-1:0]       rvfi_insn,
  input  logic [32*NRET-1:0]       rvfi_pc_rdata,
  input  logic [32*NRET-1:0]       rvfi_rd_wdata,
  input  logic [5*NRET-1:0]        rvfi_rd_addr,
  input  logic [NRET-1:0]          rvfi_trap,
  input  logic [1:0]               mode_i,
  input  logic                     arm_i,
  input  logic                     stop_i,
  input  logic                     flush_i,
  input  logic [31:0]              trig_pc_i,
  input  logic                     trig_pc_en_i,
  output logic                     tr_valid_o,
  input  logic                     tr_ready_i,
  output logic [ENTRY_W-1:0]       tr_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              drop_cnt_o,
  output logic [1:0]               state_o,
  output logic                     done_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = LVL_W + 1;

  trace_state_e       state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [LVL_W-1:0]   level_q, level_nxt;
  logic [LVL_W-1:0]   post_cnt_q, post_n;
  logic [15:0]        drop_q;
  logic [16:0]        drop_sum;

  trace_mode_e        mode;
  logic               overwrite, trig_mode;
  logic               capture, pop, arm_take;
  logic               in_post, trig_hit, done_hit;
  logic [CNT_W-1:0]   free, n_acc, n_drop, sum, ovf;

  trace_entry_t [NRET-1:0]    wr_entry;
  logic [NRET-1:0]            chan_trig;
  logic [NRET-1:0]            we;
  logic [NRET-1:0][PTR_W-1:0] waddr;
  logic [ENTRY_W-1:0]         rdata;

`ifdef RVFI_TRACE_TS_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_q + 32'd1;
  end
`endif

  assign mode      = trace_mode_e'(mode_i);
  assign overwrite = (mode == MODE_RING) || (mode == MODE_TRIGGER);
  assign trig_mode = (mode == MODE_TRIGGER);

  // Flush and reset both suppress all pushes and pops for the cycle.
  assign capture = ((state_q == ST_ARMED) || (state_q == ST_POST)) && !flush_i && !rst_i;
  assign pop     = tr_valid_o && tr_ready_i && !flush_i;
  assign free    = CNT_W'(DEPTH) - CNT_W'(level_q) + CNT_W'(pop);

  always_comb begin
    wr_entry  = '0;
    chan_trig = '0;
    for (int ch = 0; ch < NRET; ch++) begin
      wr_entry[ch].order    = rvfi_order[64*ch +: 64];
      wr_entry[ch].pc       = rvfi_pc_rdata[32*ch +: 32];
      wr_entry[ch].insn     = rvfi_insn[32*ch +: 32];
      wr_entry[ch].rd_addr  = rvfi_rd_addr[5*ch +: 5];
      wr_entry[ch].rd_wdata = rvfi_rd_wdata[32*ch +: 32];
      wr_entry[ch].trap     = rvfi_trap[ch];
`ifdef RVFI_TRACE_TS_EN
      wr_entry[ch].ts       = ts_q;
`endif
      chan_trig[ch] = rvfi_trap[ch] ||
                      (trig_pc_en_i && (rvfi_pc_rdata[32*ch +: 32] == trig_pc_i));
    end
  end

  // Walk channels in index order so slot assignment, trigger detection and the
  // POST_TRIG cut-off all see the same sequence the core retired in.
  // NOTE: blocking assignments here are intentional: each channel builds on the running counts of the previous ones.
  always_comb begin
    we       = '0;
    waddr    = '0;
    n_acc    = '0;
    n_drop   = '0;
    in_post  = (state_q == ST_POST);
    post_n   = post_cnt_q;
    trig_hit = 1'b0;
    done_hit = 1'b0;
    for (int ch = 0; ch < NRET; ch++) begin
      if (capture && rvfi_valid[ch] && !done_hit) begin
        if (!overwrite && (n_acc >= free)) begin
          n_drop = n_drop + CNT_W'(1);
        end else begin
          we[ch]    = 1'b1;
          waddr[ch] = wr_ptr_q + PTR_W'(n_acc);
          n_acc     = n_acc + CNT_W'(1);
          if (trig_mode && (state_q == ST_ARMED) && !in_post && chan_trig[ch]) begin
            in_post  = 1'b1;
            trig_hit = 1'b1;
          end
          if (in_post) begin
            post_n = post_n + LVL_W'(1);
            if (post_n == LVL_W'(POST_TRIG)) done_hit = 1'b1;
          end
        end
      end
    end
  end

  // Anything above DEPTH after this cycle's pushes replaced the oldest entries.
  always_comb begin
    sum       = CNT_W'(level_q) - CNT_W'(pop) + n_acc;
    ovf       = (sum > CNT_W'(DEPTH)) ? (sum - CNT_W'(DEPTH)) : '0;
    level_nxt = LVL_W'(sum - ovf);
    drop_sum  = 17'(drop_q) + 17'(n_drop) + 17'(ovf);
  end

  always_comb begin
    state_d  = state_q;
    arm_take = 1'b0;
    if (stop_i) begin
      state_d = ST_IDLE;
    end else if (arm_i && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
      state_d  = ST_ARMED;
      arm_take = 1'b1;
    end else if (done_hit) begin
      state_d = ST_DONE;
    end else if (trig_hit) begin
      state_d = ST_POST;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      post_cnt_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(pop) + PTR_W'(ovf);
        wr_ptr_q <= wr_ptr_q + PTR_W'(n_acc);
        level_q  <= level_nxt;
      end
      if (arm_take)      drop_q <= '0;
      else if (drop_sum[16]) drop_q <= 16'hFFFF;
      else               drop_q <= drop_sum[15:0];
      post_cnt_q <= (arm_take || (state_d != ST_POST)) ? '0 : post_n;
    end
  end

  ibex_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .NRET  (NRET),
    .AW    (PTR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign tr_data_o  = rdata;
  assign tr_valid_o = (level_q != '0);
  assign level_o    = level_q;
  assign drop_cnt_o = drop_q;
  assign state_o    = state_q;
  assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Directed bench for ibex_rvfi_trace_buffer (NRET=2, DEPTH=16, POST_TRIG=8) with hand-computed expectations.
module tb_ibex_rvfi_trace_buffer;
  import ibex_trace_pkg::*;

  localparam int unsigned NRET      = 2;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned POST_TRIG = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NRET-1:0]        rvfi_valid;
  logic [64*NRET-1:0]     rvfi_order;
  logic [32*NRET-1:0]     rvfi_insn, rvfi_pc_rdata, rvfi_rd_wdata;
  logic [5*NRET-1:0]      rvfi_rd_addr;
  logic [NRET-1:0]        rvfi_trap;
  logic [1:0]             mode;
  logic                   arm, stop, flush, trig_pc_en, tr_ready;
  logic [31:0]            trig_pc;
  logic                   tr_valid, done;
  logic [ENTRY_W-1:0]     tr_data;
  logic [4:0]             level;
  logic [15:0]            drop_cnt;
  logic [1:0]             state;
  trace_entry_t           head;

  int checks   = 0;
  int failures = 0;

  assign head = trace_entry_t'(tr_data);

  always #5 clk = ~clk;

  ibex_rvfi_trace_buffer #(
    .NRET      (NRET),
    .DEPTH     (DEPTH),
    .POST_TRIG (POST_TRIG)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rvfi_valid    (rvfi_valid),
    .rvfi_order    (rvfi_order),
    .rvfi_insn     (rvfi_insn),
    .rvfi_pc_rdata (rvfi_pc_rdata),
    .rvfi_rd_wdata (rvfi_rd_wdata),
    .rvfi_rd_addr  (rvfi_rd_addr),
    .rvfi_trap     (rvfi_trap),
    .mode_i        (mode),
    .arm_i         (arm),
    .stop_i        (stop),
    .flush_i       (flush),
    .trig_pc_i     (trig_pc),
    .trig_pc_en_i  (trig_pc_en),
    .tr_valid_o    (tr_valid),
    .tr_ready_i    (tr_ready),
    .tr_data_o     (tr_data),
    .level_o       (level),
    .drop_cnt_o    (drop_cnt),
    .state_o       (state),
    .done_o        (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pc_of(input logic [63:0] o);
    return 32'h8000_0000 + {o[29:0], 2'b00};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                        input logic [1:0] trap);
    rvfi_valid    = v;
    rvfi_order    = {o1, o0};
    rvfi_pc_rdata = {pc_of(o1), pc_of(o0)};
    rvfi_insn     = {o1[31:0] ^ 32'hDEAD_BEEF, o0[31:0] ^ 32'hDEAD_BEEF};
    rvfi_rd_addr  = {o1[4:0], o0[4:0]};
    rvfi_rd_wdata = {o1[31:0] * 32'd3, o0[31:0] * 32'd3};
    rvfi_trap     = trap;
    step();
    rvfi_valid = '0;
    rvfi_trap  = '0;
  endtask

  task automatic status(input string tag, input int lvl, input int drops, input int st);
    check({tag, "_level"}, 64'(level), 64'(lvl));
    check({tag, "_drop"},  64'(drop_cnt), 64'(drops));
    check({tag, "_state"}, 64'(state), 64'(st));
  endtask

  // Pops n entries, expecting consecutive orders starting at first.
  task automatic drain(input string tag, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, head.order, 64'(first + i));
      tr_ready = 1'b1;
      step();
    end
    tr_ready = 1'b0;
    check({tag, "_empty_level"}, 64'(level), 64'd0);
    check({tag, "_empty_valid"}, 64'(tr_valid), 64'd0);
  endtask

  task automatic restart(input logic [1:0] m);
    stop = 1'b1; flush = 1'b1;
    step();
    stop = 1'b0; flush = 1'b0;
    mode = m; arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rvfi_valid = '0; rvfi_order = '0; rvfi_insn = '0; rvfi_pc_rdata = '0;
    rvfi_rd_wdata = '0; rvfi_rd_addr = '0; rvfi_trap = '0;
    mode = 2'b00; arm = 1'b0; stop = 1'b0; flush = 1'b0;
    trig_pc = '0; trig_pc_en = 1'b0; tr_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    status("reset", 0, 0, 0);
    check("reset_valid", 64'(tr_valid), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    // STREAM: overflow drops the newest retires, head stays at order 0.
    mode = 2'b00; arm = 1'b1;
    step();
    arm = 1'b0;
    check("stream_armed", 64'(state), 64'd1);
    retire(2'b01, 64'd0, 64'd0, 2'b00);
    check("stream_first_level", 64'(level), 64'd1);
    check("stream_first_order", head.order, 64'd0);
    for (int i = 1; i < 20; i++) retire(2'b01, 64'(i), 64'd0, 2'b00);
    status("stream_full", 16, 4, 1);
    check("stream_head", head.order, 64'd0);
    tr_ready = 1'b1;
    step();
    tr_ready = 1'b0;
    check("stream_pop_level", 64'(level), 64'd15);
    check("stream_pop_head", head.order, 64'd1);

    // RING: overflow overwrites the oldest entries.
    restart(2'b01);
    status("ring_armed", 0, 0, 1);
    for (int i = 0; i < 20; i++) retire(2'b01, 64'(i), 64'd0, 2'b00);
    status("ring_full", 16, 4, 1);
    check("ring_pc", 64'(head.pc), 64'(pc_of(64'd4)));
    check("ring_wdata", 64'(head.rd_wdata), 64'd12);
    drain("ring_drain", 4, 16);

    // TRIGGER: trap on order 30, eighth post entry is order 37 in a dual-retire cycle.
    restart(2'b10);
    for (int i = 0; i < 30; i++) retire(2'b01, 64'(i), 64'd0, 2'b00);
    check("trig_pre_state", 64'(state), 64'd1);
    retire(2'b01, 64'd30, 64'd0, 2'b01);
    check("trig_post_state", 64'(state), 64'd2);
    for (int i = 31; i < 37; i++) retire(2'b01, 64'(i), 64'd0, 2'b00);
    check("trig_done_before", 64'(done), 64'd0);
    retire(2'b11, 64'd37, 64'd38, 2'b00);
    check("trig_done", 64'(done), 64'd1);
    status("trig_after", 16, 22, 3);
    for (int i = 39; i < 42; i++) retire(2'b01, 64'(i), 64'd0, 2'b00);
    status("trig_ignored", 16, 22, 3);
    check("trig_head_trap", 64'(head.trap), 64'd0);
    drain("trig_drain", 22, 16);

    // NRET=2 at level 15: dual push with a simultaneous pop fits exactly.
    restart(2'b00);
    for (int i = 0; i < 15; i++) retire(2'b01, 64'(i), 64'd0, 2'b00);
    check("dual_pre_level", 64'(level), 64'd15);
    tr_ready = 1'b1;
    retire(2'b11, 64'd15, 64'd16, 2'b00);
    tr_ready = 1'b0;
    status("dual_pop", 16, 0, 1);
    check("dual_head", head.order, 64'd1);
    retire(2'b11, 64'd17, 64'd18, 2'b00);
    status("dual_full_drop", 16, 2, 1);
    drain("dual_drain", 1, 16);

    // Flush combined with stop / arm, then reset in POST.
    retire(2'b01, 64'd50, 64'd0, 2'b00);
    retire(2'b01, 64'd51, 64'd0, 2'b00);
    check("flush_pre_level", 64'(level), 64'd2);
    flush = 1'b1; stop = 1'b1; tr_ready = 1'b1;
    retire(2'b01, 64'd52, 64'd0, 2'b00);
    flush = 1'b0; stop = 1'b0; tr_ready = 1'b0;
    status("flush_stop", 0, 2, 0);
    check("flush_stop_valid", 64'(tr_valid), 64'd0);
    arm = 1'b1; stop = 1'b1;
    step();
    arm = 1'b0; stop = 1'b0;
    status("stop_wins", 0, 2, 0);
    mode = 2'b10; arm = 1'b1; flush = 1'b1;
    step();
    arm = 1'b0; flush = 1'b0;
    status("flush_arm", 0, 0, 1);
    retire(2'b01, 64'd100, 64'd0, 2'b01);
    retire(2'b01, 64'd101, 64'd0, 2'b00);
    status("post_fill", 2, 0, 2);
    flush = 1'b1;
    retire(2'b01, 64'd102, 64'd0, 2'b00);
    flush = 1'b0;
    status("post_flush", 0, 0, 2);
    check("post_flush_valid", 64'(tr_valid), 64'd0);
    retire(2'b01, 64'd103, 64'd0, 2'b00);
    check("post_refill", 64'(level), 64'd1);
    rst = 1'b1; arm = 1'b1;
    retire(2'b01, 64'd104, 64'd0, 2'b01);
    rst = 1'b0; arm = 1'b0;
    status("post_reset", 0, 0, 0);
    check("post_reset_valid", 64'(tr_valid), 64'd0);
    check("post_reset_done", 64'(done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
